// File: rtl/ro_pair_counter.sv
// Ring-oscillator pair counter: counts rising edges of two asynchronous oscillators
// over a fixed clk window (or until the downstream limit flag) and latches a PUF response bit.
module ro_pair_counter #(
    parameter int WINDOW = 1000000,
    parameter int CW     = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          ro_a,
    input  logic          ro_b,
    input  logic          cnt_max,
    output logic [31:0]   cnt_live,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] cnt_a,
    output logic [CW-1:0] cnt_b,
    output logic          response,
    output logic          tie,
    output logic          early
);

    localparam int WW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [WW-1:0] WIN_LAST = WW'(WINDOW - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t state_reg, state_next;

    // Index 0 is oscillator A, index 1 is oscillator B.
    logic [1:0] ro_vec;
    logic [1:0] sync1_reg, sync2_reg, hist_reg;
    logic [1:0] edge_det;

    logic [1:0][CW-1:0] cnt_reg, cnt_next;
    logic [WW-1:0]      win_reg, win_next;
    logic               run_exit;

    logic [CW-1:0] cnt_a_reg, cnt_b_reg;
    logic          response_reg, tie_reg, early_reg;

    assign ro_vec   = {ro_b, ro_a};
    assign edge_det = sync2_reg & ~hist_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
            hist_reg  <= '0;
        end else begin
            sync1_reg <= ro_vec;
            sync2_reg <= sync1_reg;
            hist_reg  <= sync2_reg;
        end
    end

    assign run_exit = (state_reg == S_RUN) && ((win_reg == WIN_LAST) || cnt_max);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (start) state_next = S_RUN;
            S_RUN:   if (run_exit) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Edge counters saturate instead of wrapping; an edge in the exit cycle still counts.
    always_comb begin
        cnt_next = cnt_reg;
        win_next = win_reg;
        if (state_reg == S_IDLE && start) begin
            cnt_next = '0;
            win_next = '0;
        end else if (state_reg == S_RUN) begin
            win_next = win_reg + 1'b1;
            for (int i = 0; i < 2; i++) begin
                if (edge_det[i] && (cnt_reg[i] != {CW{1'b1}}))
                    cnt_next[i] = cnt_reg[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            win_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            win_reg   <= win_next;
        end
    end

    // Results are captured from the post-increment counts so they appear with done.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_a_reg    <= '0;
            cnt_b_reg    <= '0;
            response_reg <= 1'b0;
            tie_reg      <= 1'b0;
            early_reg    <= 1'b0;
        end else if (run_exit) begin
            cnt_a_reg    <= cnt_next[0];
            cnt_b_reg    <= cnt_next[1];
            response_reg <= (cnt_next[0] > cnt_next[1]);
            tie_reg      <= (cnt_next[0] == cnt_next[1]);
            early_reg    <= cnt_max;
        end
    end

    generate
        if (CW >= 32) begin : g_live_trunc
            assign cnt_live = cnt_reg[0][31:0];
        end else begin : g_live_ext
            assign cnt_live = {{(32 - CW){1'b0}}, cnt_reg[0]};
        end
    endgenerate

    assign busy     = (state_reg == S_RUN);
    assign done     = (state_reg == S_DONE);
    assign cnt_a    = cnt_a_reg;
    assign cnt_b    = cnt_b_reg;
    assign response = response_reg;
    assign tie      = tie_reg;
    assign early    = early_reg;

endmodule

// File: tb/tb_ro_pair_counter.sv
// Scoreboard bench for ro_pair_counter: directed runs push expected results,
// per-DUT monitors pop and compare on every done pulse.
module tb_ro_pair_counter;

    localparam int WIN = 100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, ro_a, ro_b, cnt_max;
    logic [31:0] cnt_live;
    logic        busy, done, response, tie, early;
    logic [31:0] cnt_a, cnt_b;

    logic        start2, ro_a2, ro_b2, cnt_max2;
    logic [31:0] cnt_live_2;
    logic        busy_2, done_2, response_2, tie_2, early_2;
    logic [3:0]  cnt_a_2, cnt_b_2;

    ro_pair_counter #(.WINDOW(WIN), .CW(32)) dut (
        .clk(clk), .rst(rst), .start(start), .ro_a(ro_a), .ro_b(ro_b), .cnt_max(cnt_max),
        .cnt_live(cnt_live), .busy(busy), .done(done), .cnt_a(cnt_a), .cnt_b(cnt_b),
        .response(response), .tie(tie), .early(early)
    );

    ro_pair_counter #(.WINDOW(WIN), .CW(4)) dut_sat (
        .clk(clk), .rst(rst), .start(start2), .ro_a(ro_a2), .ro_b(ro_b2), .cnt_max(cnt_max2),
        .cnt_live(cnt_live_2), .busy(busy_2), .done(done_2), .cnt_a(cnt_a_2), .cnt_b(cnt_b_2),
        .response(response_2), .tie(tie_2), .early(early_2)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          at;
        int          run;
        logic [31:0] a;
        logic [31:0] b;
        logic        resp;
        logic        tie;
        logic        early;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   dones1   = 0;
    int   dones2   = 0;
    int   run1     = 0;
    int   run2     = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_done(input string tag, input exp_t e, input int at, input int run,
                              input logic bsy, input logic [31:0] a, input logic [31:0] b,
                              input logic r, input logic t, input logic er);
        chk({tag, " done_cycle"}, at, e.at);
        chk({tag, " run_len"}, run, e.run);
        chk({tag, " busy_in_done"}, {31'd0, bsy}, 32'd0);
        chk({tag, " cnt_a"}, a, e.a);
        chk({tag, " cnt_b"}, b, e.b);
        chk({tag, " response"}, {31'd0, r}, {31'd0, e.resp});
        chk({tag, " tie"}, {31'd0, t}, {31'd0, e.tie});
        chk({tag, " early"}, {31'd0, er}, {31'd0, e.early});
        $display("done %s at cycle %0d: cnt_a=%0d cnt_b=%0d resp=%0b tie=%0b early=%0b",
                 tag, at, a, b, r, t, er);
    endtask

    // Monitors: count busy cycles and check each done against the queue head.
    always @(negedge clk) begin
        if (busy) run1 <= run1 + 1;
        else if (!done) run1 <= 0;
        if (done) begin
            dones1 <= dones1 + 1;
            if (q1.size() == 0) begin
                chk("dut unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q1.pop_front();
                check_done("dut", e, cyc, run1, busy, cnt_a, cnt_b, response, tie, early);
            end
        end
    end

    always @(negedge clk) begin
        if (busy_2) run2 <= run2 + 1;
        else if (!done_2) run2 <= 0;
        if (done_2) begin
            dones2 <= dones2 + 1;
            if (q2.size() == 0) begin
                chk("dut_sat unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q2.pop_front();
                check_done("dut_sat", e, cyc, run2, busy_2, {28'd0, cnt_a_2}, {28'd0, cnt_b_2},
                           response_2, tie_2, early_2);
            end
        end
    end

    task automatic wait_cyc(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start(output int e);
        start = 1'b1;
        e = cyc + 1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic push1(input int at, input int run, input int a, input int b,
                         input logic r, input logic t, input logic er);
        exp_t e;
        e.at = at; e.run = run; e.a = a; e.b = b; e.resp = r; e.tie = t; e.early = er;
        q1.push_back(e);
    endtask

    // Toggle each oscillator every ha/hb cycles (0 = idle) for len cycles.
    task automatic osc(input int ha, input int hb, input int len);
        for (int i = 1; i <= len; i++) begin
            @(posedge clk);
            #1;
            if (ha != 0 && (i % ha) == 0) ro_a = ~ro_a;
            if (hb != 0 && (i % hb) == 0) ro_b = ~ro_b;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " cnt_live"}, cnt_live, 32'd0);
        chk({tag, " busy"}, {31'd0, busy}, 32'd0);
        chk({tag, " done"}, {31'd0, done}, 32'd0);
        chk({tag, " cnt_a"}, cnt_a, 32'd0);
        chk({tag, " cnt_b"}, cnt_b, 32'd0);
        chk({tag, " response"}, {31'd0, response}, 32'd0);
        chk({tag, " tie"}, {31'd0, tie}, 32'd0);
        chk({tag, " early"}, {31'd0, early}, 32'd0);
    endtask

    initial begin
        int e;
        rst = 1'b1; start = 1'b0; ro_a = 1'b0; ro_b = 1'b0; cnt_max = 1'b0;
        start2 = 1'b0; ro_a2 = 1'b0; ro_b2 = 1'b0; cnt_max2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        chk("reset sat_cnt_live", cnt_live_2, 32'd0);
        rst = 1'b0;
        wait_cyc(cyc + 2);

        // Basic compare: A 11 rises, B 7 rises, full window.
        pulse_start(e);
        push1(e + 100, 100, 11, 7, 1'b1, 1'b0, 1'b0);
        osc(4, 6, 88);
        wait_cyc(e + 103);
        chk("basic cnt_live_hold", cnt_live, 32'd11);

        // Tie: identical stimulus on both oscillators.
        pulse_start(e);
        push1(e + 100, 100, 9, 9, 1'b0, 1'b1, 1'b0);
        osc(5, 5, 90);
        wait_cyc(e + 103);

        // Early stop: cnt_max high in RUN cycle 37.
        pulse_start(e);
        push1(e + 37, 37, 5, 0, 1'b1, 1'b0, 1'b1);
        osc(3, 0, 30);
        wait_cyc(e + 36);
        cnt_max = 1'b1;
        wait_cyc(e + 37);
        cnt_max = 1'b0;
        wait_cyc(e + 40);

        // cnt_max coinciding with window expiry reports early.
        pulse_start(e);
        push1(e + 100, 100, 0, 0, 1'b0, 1'b1, 1'b1);
        wait_cyc(e + 99);
        cnt_max = 1'b1;
        wait_cyc(e + 100);
        cnt_max = 1'b0;
        wait_cyc(e + 103);

        // Reset mid-run: aborts with no done, then a fresh run completes.
        pulse_start(e);
        osc(4, 0, 40);
        wait_cyc(e + 49);
        chk("midrun cnt_live", cnt_live, 32'd5);
        chk("midrun busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        wait_cyc(e + 50);
        rst = 1'b0;
        chk_all_zero("after_reset");
        wait_cyc(e + 60);
        pulse_start(e);
        push1(e + 100, 100, 11, 7, 1'b1, 1'b0, 1'b0);
        osc(4, 6, 88);
        wait_cyc(e + 103);

        // Start filtering: pulses in RUN and in the done cycle are ignored.
        pulse_start(e);
        push1(e + 100, 100, 0, 0, 1'b0, 1'b1, 1'b0);
        wait_cyc(e + 9);
        start = 1'b1;
        wait_cyc(e + 10);
        start = 1'b0;
        wait_cyc(e + 100);
        start = 1'b1;
        wait_cyc(e + 101);
        start = 1'b0;
        wait_cyc(e + 250);
        chk("dut done_count", dones1, 32'd6);

        // Saturation on the 4-bit instance: 20 rises clamp at 15.
        start2 = 1'b1;
        e = cyc + 1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        begin
            exp_t s;
            s.at = e + 100; s.run = 100; s.a = 15; s.b = 0;
            s.resp = 1'b1; s.tie = 1'b0; s.early = 1'b0;
            q2.push_back(s);
        end
        for (int i = 1; i <= 80; i++) begin
            @(posedge clk);
            #1;
            if ((i % 2) == 0) ro_a2 = ~ro_a2;
        end
        wait_cyc(e + 103);
        chk("sat cnt_live", cnt_live_2, 32'd15);
        chk("dut_sat done_count", dones2, 32'd1);

        chk("dut pending_expected", q1.size(), 32'd0);
        chk("dut_sat pending_expected", q2.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
